// File: rtl/gemm_mem_pkg.sv
// Shared types and helpers for the GEMM scratchpad row sequencer.
package gemm_mem_pkg;

  localparam int NUM_RAMS = 16;
  localparam int D_WID    = 8;
  localparam int CW       = 5;

  typedef enum logic [2:0] {IDLE, RD, WR, DRAIN, FIN} seq_state_e;

  typedef logic [NUM_RAMS-1:0][D_WID-1:0] row_t;

  // Row byte counts above the bank count saturate at a full row.
  function automatic logic [CW-1:0] clamp_row_bytes(input logic [CW-1:0] rb);
    return (rb > CW'(NUM_RAMS)) ? CW'(NUM_RAMS) : rb;
  endfunction

endpackage

// File: rtl/gemm_row_skid_buf.sv
// Two-entry ready/valid buffer; an arriving word bypasses straight to the
// output when the buffer is empty and the consumer is ready.
module gemm_row_skid_buf #(
  parameter int W = 128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic [1:0]   occupancy
);

  logic [W-1:0] buf_reg [2];
  logic         head_reg;
  logic         tail_reg;
  logic [1:0]   count_reg;
  logic         bypass;
  logic         push;
  logic         pop;

  assign out_valid = (count_reg != 2'd0) || in_valid;
  assign out_data  = (count_reg != 2'd0) ? buf_reg[head_reg] : in_data;
  assign bypass    = (count_reg == 2'd0) && in_valid && out_ready;
  assign push      = in_valid && !bypass;
  assign pop       = (count_reg != 2'd0) && out_ready;
  assign occupancy = count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg  <= 1'b0;
      tail_reg  <= 1'b0;
      count_reg <= 2'd0;
      for (int i = 0; i < 2; i++) buf_reg[i] <= '0;
    end else begin
      if (push) begin
        buf_reg[tail_reg] <= in_data;
        tail_reg          <= ~tail_reg;
      end
      if (pop) head_reg <= ~head_reg;
      count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/gemm_mem_row_sequencer.sv
// Expands one start command into strided row reads or writes on the
// scratchpad interface port, with ready/valid streams on both sides.
module gemm_mem_row_sequencer #(
  parameter int NUM_RAMS = 16,
  parameter int D_WID    = 8,
  parameter int CW       = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      mode,
  input  logic [31:0]               base_addr,
  input  logic [31:0]               stride,
  input  logic [CW-1:0]             num_rows,
  input  logic [CW-1:0]             row_bytes,
  output logic                      busy,
  output logic                      done,
  output logic [NUM_RAMS*D_WID-1:0] rd_data,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  input  logic [NUM_RAMS*D_WID-1:0] wr_data,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  output logic                      mem_en,
  output logic                      mem_rdwr,
  output logic [CW-1:0]             mem_control,
  output logic [31:0]               mem_addr,
  output logic [NUM_RAMS*D_WID-1:0] mem_wr_data,
  input  logic [NUM_RAMS*D_WID-1:0] mem_rd_data
);
  import gemm_mem_pkg::*;

  localparam int W = NUM_RAMS * D_WID;

  seq_state_e    state_reg;
  logic [31:0]   acc_reg;
  logic [31:0]   stride_reg;
  logic [CW-1:0] rows_reg;
  logic [CW-1:0] issued_reg;
  logic [CW-1:0] len_reg;
  logic          pend_reg;
  logic          busy_reg;
  logic          done_reg;

  logic [1:0]    occupancy;
  logic [W-1:0]  skid_in;
  logic          rd_issue;
  logic          wr_fire;
  logic          rd_fire;
  logic          last_issue;
  logic          drain_empty;

  // Read-ahead is bounded by the two skid slots, counting the row in flight.
  assign rd_issue   = (state_reg == RD) && ((2'(pend_reg) + occupancy) < 2'd2);
  assign wr_fire    = (state_reg == WR) && wr_valid;
  assign rd_fire    = rd_valid && rd_ready;
  assign last_issue = (issued_reg == rows_reg - CW'(1));
  assign drain_empty = (({1'b0, occupancy} + {2'b0, pend_reg} - {2'b0, rd_fire}) == 3'd0);

  assign mem_en      = rd_issue || wr_fire;
  assign mem_rdwr    = wr_fire;
  assign mem_control = mem_en ? len_reg : '0;
  assign mem_addr    = mem_en ? acc_reg : '0;
  assign mem_wr_data = wr_fire ? wr_data : '0;
  assign wr_ready    = (state_reg == WR);
  assign busy        = busy_reg;
  assign done        = done_reg;

  // Returned bytes beyond the row length are forced to zero before buffering.
  generate
    for (genvar gi = 0; gi < NUM_RAMS; gi++) begin : g_mask
      assign skid_in[gi*D_WID +: D_WID] = (pend_reg && (CW'(gi) < len_reg)) ?
                                          mem_rd_data[gi*D_WID +: D_WID] : '0;
    end
  endgenerate

  gemm_row_skid_buf #(.W(W)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (pend_reg),
    .in_data   (skid_in),
    .out_valid (rd_valid),
    .out_data  (rd_data),
    .out_ready (rd_ready),
    .occupancy (occupancy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      acc_reg    <= '0;
      stride_reg <= '0;
      rows_reg   <= '0;
      issued_reg <= '0;
      len_reg    <= '0;
      pend_reg   <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      pend_reg <= rd_issue;
      if (mem_en) begin
        acc_reg    <= acc_reg + stride_reg;
        issued_reg <= issued_reg + CW'(1);
      end
      case (state_reg)
        IDLE: if (start) begin
          acc_reg    <= base_addr;
          stride_reg <= stride;
          rows_reg   <= num_rows;
          issued_reg <= '0;
          len_reg    <= clamp_row_bytes(row_bytes);
          busy_reg   <= 1'b1;
          if (num_rows == '0) state_reg <= FIN;
          else                state_reg <= mode ? WR : RD;
        end
        RD: if (rd_issue && last_issue) state_reg <= DRAIN;
        WR: if (wr_fire && last_issue) begin
          state_reg <= FIN;
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
        end
        DRAIN: if (drain_empty) begin
          state_reg <= FIN;
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
        end
        // An empty command arrives here still busy and pulses done on the way out.
        FIN: if (busy_reg) begin
          done_reg <= 1'b1;
          busy_reg <= 1'b0;
        end else begin
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gemm_mem_row_sequencer.sv
// Scoreboard bench for the row sequencer against a byte-addressed memory model.
module tb_gemm_mem_row_sequencer;
  import gemm_mem_pkg::*;

  localparam int W = NUM_RAMS * D_WID;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic [31:0]   base_addr = '0;
  logic [31:0]   stride = '0;
  logic [CW-1:0] num_rows = '0;
  logic [CW-1:0] row_bytes = '0;
  logic          busy, done, rd_valid, wr_ready, mem_en, mem_rdwr;
  logic [W-1:0]  rd_data, mem_wr_data;
  logic          rd_ready = 1'b1;
  logic [W-1:0]  wr_data = '0;
  logic          wr_valid = 1'b0;
  logic [CW-1:0] mem_control;
  logic [31:0]   mem_addr;
  logic [W-1:0]  mem_rd_data = '0;

  gemm_mem_row_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .base_addr(base_addr), .stride(stride), .num_rows(num_rows), .row_bytes(row_bytes),
    .busy(busy), .done(done), .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .mem_en(mem_en), .mem_rdwr(mem_rdwr), .mem_control(mem_control), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]   addr;
    logic          rdwr;
    logic [CW-1:0] ctrl;
    logic [W-1:0]  wdata;
  } op_t;

  op_t          exp_op_q[$];
  logic [W-1:0] exp_rd_q[$];
  int           issue_cyc_q[$];

  int n_checks = 0, n_fail = 0;
  int cyc = 0, start_cyc = 0;
  int done_cnt = 0, mem_en_cnt = 0, busy_cnt = 0;
  int rd_issue_cnt = 0, rd_pop_cnt = 0, last_fire_cyc = 0, done_cyc = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory model: untouched bytes read back a pattern derived from the address.
  logic [7:0] wmem [logic [31:0]];

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    if (wmem.exists(a)) return wmem[a];
    return a[7:0] ^ 8'h5A;
  endfunction

  always @(posedge clk)
    if (mem_en && !mem_rdwr)
      for (int i = 0; i < NUM_RAMS; i++) mem_rd_data[i*D_WID +: D_WID] <= mem_byte(mem_addr + 32'(i));

  always @(posedge clk)
    if (mem_en && mem_rdwr)
      for (int i = 0; i < NUM_RAMS; i++)
        if (i < int'(mem_control)) wmem[mem_addr + 32'(i)] = mem_wr_data[i*D_WID +: D_WID];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    op_t op;
    if (!rst_n) begin
      rd_issue_cnt = rd_pop_cnt;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (mem_en) begin
        mem_en_cnt++;
        issue_cyc_q.push_back(cyc);
        if (!mem_rdwr) begin
          check("read_ahead", W'((rd_issue_cnt - rd_pop_cnt) < 2), W'(1));
          rd_issue_cnt++;
        end
        check("mem_op_expected", W'(exp_op_q.size() != 0), W'(1));
        if (exp_op_q.size() != 0) begin
          op = exp_op_q.pop_front();
          $display("mem op cyc=%0d rdwr=%0b addr=%08h ctrl=%0d", cyc, mem_rdwr, mem_addr, mem_control);
          check("mem_addr", W'(mem_addr), W'(op.addr));
          check("mem_rdwr", W'(mem_rdwr), W'(op.rdwr));
          check("mem_control", W'(mem_control), W'(op.ctrl));
          if (op.rdwr) check("mem_wr_data", mem_wr_data, op.wdata);
        end
      end
      if (rd_valid && rd_ready) begin
        rd_pop_cnt++;
        last_fire_cyc = cyc;
        check("rd_beat_expected", W'(exp_rd_q.size() != 0), W'(1));
        if (exp_rd_q.size() != 0) begin
          $display("rd beat cyc=%0d data=%032h", cyc, rd_data);
          check("rd_data", rd_data, exp_rd_q.pop_front());
        end
      end
      if (wr_valid && wr_ready) last_fire_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_cmd(input logic m, input logic [31:0] b, input logic [31:0] s,
                           input logic [CW-1:0] n, input logic [CW-1:0] l);
    start_cyc = cyc;
    mode = m; base_addr = b; stride = s; num_rows = n; row_bytes = l;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic expect_reads(input logic [31:0] b, input logic [31:0] s,
                              input logic [CW-1:0] n, input logic [CW-1:0] l);
    logic [CW-1:0] cl;
    logic [31:0]   a;
    logic [W-1:0]  row;
    op_t           op;
    cl = (l > 5'd16) ? 5'd16 : l;
    for (int r = 0; r < int'(n); r++) begin
      a = b + s * 32'(r);
      op = '{addr: a, rdwr: 1'b0, ctrl: cl, wdata: '0};
      exp_op_q.push_back(op);
      for (int i = 0; i < NUM_RAMS; i++)
        row[i*D_WID +: D_WID] = (i < int'(cl)) ? mem_byte(a + 32'(i)) : 8'h00;
      exp_rd_q.push_back(row);
    end
  endtask

  task automatic wait_done(input int base_cnt);
    for (int k = 0; k < 200 && done_cnt == base_cnt; k++) tick();
    check("done_seen", W'(done_cnt > base_cnt), W'(1));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ctrl"}, W'({busy, done, rd_valid, wr_ready, mem_en, mem_rdwr, mem_control, mem_addr}), '0);
    check({tag, "_rd_data"}, rd_data, '0);
    check({tag, "_wr_data"}, mem_wr_data, '0);
  endtask

  task automatic check_queues_empty(input string tag);
    check({tag, "_ops_left"}, W'(exp_op_q.size()), '0);
    check({tag, "_rows_left"}, W'(exp_rd_q.size()), '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, e0, b0;
    logic [W-1:0] wd0, wd1, row;
    logic [31:0]  a, wa;
    op_t          op;

    // Reset state
    repeat (3) tick();
    check_idle_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Streaming read with consumer always ready
    rd_ready = 1'b1;
    issue_cyc_q.delete();
    d0 = done_cnt;
    expect_reads(32'h100, 32'h10, 5'd4, 5'd16);
    issue_cmd(1'b0, 32'h100, 32'h10, 5'd4, 5'd16);
    wait_done(d0);
    check("rd4_issues", W'(issue_cyc_q.size()), W'(4));
    if (issue_cyc_q.size() >= 4) begin
      check("rd4_first_issue", W'(issue_cyc_q[0] - start_cyc), W'(1));
      check("rd4_consecutive", W'(issue_cyc_q[3] - issue_cyc_q[0]), W'(3));
      check("rd4_last_beat", W'(last_fire_cyc - issue_cyc_q[3]), W'(1));
    end
    check("rd4_done_latency", W'(done_cyc - last_fire_cyc), W'(1));
    check_queues_empty("rd4");

    // Consumer stalled: only two rows may be read ahead
    rd_ready = 1'b0;
    e0 = mem_en_cnt;
    d0 = done_cnt;
    expect_reads(32'h300, 32'h40, 5'd3, 5'd16);
    issue_cmd(1'b0, 32'h300, 32'h40, 5'd3, 5'd16);
    repeat (10) tick();
    check("stall_issues", W'(mem_en_cnt - e0), W'(2));
    check("stall_rd_valid", W'(rd_valid), W'(1));
    rd_ready = 1'b1;
    wait_done(d0);
    check("stall_total_issues", W'(mem_en_cnt - e0), W'(3));
    check_queues_empty("stall");

    // Partial-row writes with a gap in wr_valid
    wd0 = {$urandom, $urandom, $urandom, $urandom};
    wd1 = {$urandom, $urandom, $urandom, $urandom};
    op = '{addr: 32'h205, rdwr: 1'b1, ctrl: 5'd5, wdata: wd0};
    exp_op_q.push_back(op);
    op = '{addr: 32'h225, rdwr: 1'b1, ctrl: 5'd5, wdata: wd1};
    exp_op_q.push_back(op);
    d0 = done_cnt;
    issue_cmd(1'b1, 32'h205, 32'h20, 5'd2, 5'd5);
    wr_valid = 1'b1; wr_data = wd0;
    tick();
    wr_valid = 1'b0;
    tick();
    wr_valid = 1'b1; wr_data = wd1;
    tick();
    wr_valid = 1'b0;
    check("wr_ready_drop", W'(wr_ready), W'(0));
    check("wr_done_next", W'(done), W'(1));
    wait_done(d0);
    check_queues_empty("wr");

    // Read the written area back: five new bytes per row, neighbours intact
    for (int r = 0; r < 2; r++) begin
      a  = 32'h200 + 32'h20 * 32'(r);
      wa = a + 32'h5;
      op = '{addr: a, rdwr: 1'b0, ctrl: 5'd16, wdata: '0};
      exp_op_q.push_back(op);
      for (int i = 0; i < NUM_RAMS; i++) begin
        if (i >= 5 && i < 10) row[i*D_WID +: D_WID] = (r == 0) ? wd0[(i-5)*D_WID +: D_WID] : wd1[(i-5)*D_WID +: D_WID];
        else                  row[i*D_WID +: D_WID] = (a[7:0] + 8'(i)) ^ 8'h5A;
      end
      exp_rd_q.push_back(row);
    end
    d0 = done_cnt;
    issue_cmd(1'b0, 32'h200, 32'h20, 5'd2, 5'd16);
    wait_done(d0);
    check_queues_empty("readback");

    // Empty command, with a start offered during FIN that must be ignored
    e0 = mem_en_cnt;
    b0 = busy_cnt;
    d0 = done_cnt;
    issue_cmd(1'b0, 32'h400, 32'h10, 5'd0, 5'd16);
    num_rows = 5'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(d0);
    repeat (4) tick();
    check("zero_no_mem", W'(mem_en_cnt - e0), W'(0));
    check("zero_busy_cycles", W'(busy_cnt - b0), W'(1));
    check("zero_done_latency", W'(done_cyc - start_cyc), W'(2));
    check("zero_single_done", W'(done_cnt - d0), W'(1));

    // Address accumulator wraps at 2^32
    d0 = done_cnt;
    expect_reads(32'hFFFF_FFF0, 32'h20, 5'd2, 5'd16);
    issue_cmd(1'b0, 32'hFFFF_FFF0, 32'h20, 5'd2, 5'd16);
    wait_done(d0);
    check_queues_empty("wrap");

    // Zero-length rows and an over-long row length
    d0 = done_cnt;
    expect_reads(32'h500, 32'h10, 5'd2, 5'd0);
    issue_cmd(1'b0, 32'h500, 32'h10, 5'd2, 5'd0);
    wait_done(d0);
    d0 = done_cnt;
    expect_reads(32'h600, 32'h10, 5'd1, 5'd20);
    issue_cmd(1'b0, 32'h600, 32'h10, 5'd1, 5'd20);
    wait_done(d0);
    check_queues_empty("len_edge");

    // Reset while a read is outstanding
    rd_ready = 1'b0;
    expect_reads(32'h700, 32'h10, 5'd4, 5'd16);
    issue_cmd(1'b0, 32'h700, 32'h10, 5'd4, 5'd16);
    tick();
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midreset");
    exp_op_q.delete();
    exp_rd_q.delete();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("post_reset_rd_valid", W'(rd_valid), W'(0));
    rd_ready = 1'b1;
    d0 = done_cnt;
    expect_reads(32'h100, 32'h10, 5'd2, 5'd8);
    issue_cmd(1'b0, 32'h100, 32'h10, 5'd2, 5'd8);
    wait_done(d0);
    check_queues_empty("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gemm_mem_row_sequencer.md
Name: gemm_mem_row_sequencer

Overview:
- Sequences the interface port (port A) of the GEMM banked scratchpad memory.
- Turns a single start command into a stream of row accesses: num_rows rows at base_addr + r*stride, row_bytes bytes each.
- Read mode: streams rows to the systolic-array feeder over ready/valid. Write mode: accepts result rows over ready/valid and stores them.
- Sits between the GEMM control FSM and the memory interface port. The system-bus port is untouched.

Parameters:
- NUM_RAMS, 16, number of byte banks (bytes per row beat).
- D_WID, 8, bits per bank.
- CW, 5, width of row count and row byte count fields.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  command strobe; sampled only in IDLE.
- mode  in  1  0 = read rows, 1 = write rows; latched at start.
- base_addr  in  32  byte address of row 0; latched at start.
- stride  in  32  byte distance between rows; latched at start.
- num_rows  in  CW  rows to transfer, 0..16; latched at start.
- row_bytes  in  CW  valid bytes per row, 0..16, values >16 clamp to 16; latched at start.
- busy  out  1  high from the cycle after start until the done pulse.
- done  out  1  one-cycle completion pulse.
- rd_data  out  NUM_RAMS*D_WID  row data; bytes at and above row_bytes are zero.
- rd_valid  out  1  rd_data valid.
- rd_ready  in  1  consumer accepts rd_data.
- wr_data  in  NUM_RAMS*D_WID  row to store.
- wr_valid  in  1  wr_data valid.
- wr_ready  out  1  sequencer accepts wr_data.
- mem_en  out  1  to memory interface_en.
- mem_rdwr  out  1  to memory interface_rdwr (1 = write).
- mem_control  out  CW  to memory interface_control (byte mask length).
- mem_addr  out  32  to memory interface_addr.
- mem_wr_data  out  NUM_RAMS*D_WID  to memory interface_wr_data.
- mem_rd_data  in  NUM_RAMS*D_WID  from memory interface_rd_data; valid 1 cycle after a read issue.

Behaviour:
- Reset, asynchronous: all outputs 0; FSM to IDLE; row counters, address accumulator and skid buffer cleared. Reset mid-transfer discards in-flight data. The memory read returning after reset deasserts is ignored.
- FSM states: IDLE, RD, WR, DRAIN, FIN.
- IDLE transitions on start:
  - num_rows==0 goes to FIN, with no memory access.
  - Otherwise goes to RD or WR per mode.
  - start is ignored in every state other than IDLE.
- Addressing:
  - An accumulator is loaded with base_addr at start and adds stride after each issued row.
  - Modulo 2^32; wrap-around is silent.
  - No multiplier.
- mem_control equals the clamped row_bytes for the whole command. mem_addr, mem_rdwr and mem_control are driven only while mem_en is high, and are 0 otherwise.
- RD state:
  - Issue a read (mem_en=1, mem_rdwr=0) when outstanding + skid occupancy < 2.
  - Data captured into the 2-entry skid buffer the cycle after issue.
  - rd_valid = buffer non-empty. Pop on rd_valid && rd_ready.
  - With rd_ready held high: issue cycle N, rd_valid cycle N+1. Throughput is 1 row/cycle.
  - After the last issue go to DRAIN. Leave DRAIN when the buffer is empty and nothing is outstanding.
- WR state:
  - wr_ready=1. Each wr_valid && wr_ready cycle drives mem_en=1, mem_rdwr=1, mem_wr_data=wr_data, and mem_addr from the accumulator, in the same cycle (combinational pass-through).
  - wr_ready drops combinationally on the beat after the last row is accepted.
  - After the last row go to FIN.
- FIN: done=1 for one cycle, busy=0 on that cycle and after; return to IDLE. A start in the FIN cycle is ignored.
- Simultaneous push and pop on the skid buffer in the same cycle keeps occupancy constant.
- rd_ready low indefinitely: at most 2 rows are read ahead, then issue stalls. No data loss.
- row_bytes==0: rows are still issued with mem_control=0, and returned data is all zero.

Decomposition:
- Package gemm_mem_pkg:
  - seq_state_e enum (IDLE, RD, WR, DRAIN, FIN).
  - NUM_RAMS, D_WID, CW defaults.
  - row_t typedef (logic [NUM_RAMS-1:0][D_WID-1:0]).
  - Clamp function for row_bytes.
- Sub-module gemm_row_skid_buf: 2-entry ready/valid buffer with occupancy output, instantiated for the read path.

Test Plan:
- Read, base=0x100, stride=0x10, num_rows=4, row_bytes=16, rd_ready=1 → mem_addr 0x100, 0x110, 0x120, 0x130 on 4 consecutive cycles; 4 rd_valid beats matching preloaded rows; done exactly one cycle after the last beat is accepted.
- Read, num_rows=3, rd_ready=0 for 10 cycles then 1 → exactly 2 issues before the stall; third issue only after the first pop; rows delivered in order; no duplicates.
- Write, base=0x205, stride=0x20, num_rows=2, row_bytes=5, wr_valid toggling 1,0,1 → 2 writes at 0x205 and 0x225 with mem_control=5; readback shows bytes 0..4 updated and the neighbouring bytes unchanged.
- num_rows=0 → no mem_en pulse; done one cycle after the FIN entry; busy high for exactly 1 cycle.
- base=0xFFFFFFF0, stride=0x20, num_rows=2 → second mem_addr is 0x00000010 (wrap-around).
- rst_n asserted mid-read with 1 row outstanding → all outputs 0 immediately; after release, rd_valid stays 0 and a new start runs cleanly.
